// File: rtl/pwm_if.sv
// Register-file to PWM-peripheral bundle: enable/duty registers in, pins and period marker out.
// No handshake: inputs are quasi-static clk-domain levels, outputs are registered levels/pulses.
interface pwm_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        input  out, period_start
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        output out, period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: prescaler, free-running 256-step period counter, period-shadowed
// duty value and a registered per-pin off/high/PWM mux.
module pwm_peripheral #(
    parameter int PRESCALE = 13
) (
    input  logic  clk,
    input  logic  rst_n,
    pwm_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] prescale_q, prescale_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    duty_q, duty_d;
    logic [15:0]   out_q, out_d;
    logic          period_start_q, period_start_d;

    logic          tick;
    logic          wrap;
    logic          pwm_sig;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;

    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    always_comb begin
        tick           = (prescale_q == PW'(PRESCALE - 1));
        wrap           = tick && (cnt_q == 8'hFF);
        prescale_d     = tick ? '0 : prescale_q + 1'b1;
        cnt_d          = tick ? cnt_q + 8'd1 : cnt_q;
        // Duty is only sampled on the wrap so a period never mixes two duty values.
        duty_d         = wrap ? bus.pwm_duty_cycle : duty_q;
        period_start_d = wrap;
        // 0xFF is forced high so full duty has no low step at counter 255.
        pwm_sig        = (duty_q == 8'hFF) || (cnt_q < duty_q);
        out_d          = en_out & (~en_pwm | {16{pwm_sig}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q     <= '0;
            cnt_q          <= '0;
            duty_q         <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            prescale_q     <= prescale_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = period_start_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: arithmetic cycle model checked every cycle, plus directed
// literal expectations for pulse widths, period length and reset behaviour.
`timescale 1ns/1ps
module tb_pwm_peripheral;
  localparam int P      = 13;
  localparam int PERIOD = 256 * P;

  logic clk;
  logic rst_n;
  pwm_if bus ();

  pwm_peripheral #(.PRESCALE(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp;
  int n_fail;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // behavioural model: position in time -> counter, period -> duty
  int unsigned k;
  logic [7:0]  m_duty;
  logic [15:0] exp_out;
  logic        exp_ps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; m_duty = 8'h00; exp_out = 16'h0000; exp_ps = 1'b0;
    end else begin
      int cnt;
      logic pwm;
      logic [15:0] eo, ep;
      cnt = (k / P) % 256;
      pwm = (m_duty == 8'hFF) || (cnt < int'(m_duty));
      eo  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
      ep  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
      for (int i = 0; i < 16; i++)
        exp_out[i] = eo[i] ? (ep[i] ? pwm : 1'b1) : 1'b0;
      k++;
      exp_ps = ((k % PERIOD) == 0);
      if (exp_ps) m_duty = bus.pwm_duty_cycle;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (bus.out !== exp_out || bus.period_start !== exp_ps) begin
        n_fail++;
        $display("FAIL cycle_model @%0t: out=0x%04h ps=%0b expected out=0x%04h ps=%0b",
                 $time, bus.out, bus.period_start, exp_out, exp_ps);
      end
    end
  end

  // scoreboard side: high-cycle count of out[0] per period, period_start count, cycles since reset
  int hi_acc, last_hi, ps_count, cyc, first_ps_cyc;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      hi_acc = 0; cyc = 0; first_ps_cyc = 0;
    end else begin
      cyc++;
      hi_acc += int'(bus.out[0]);
      if (bus.period_start) begin
        last_hi = hi_acc;
        hi_acc  = 0;
        ps_count++;
        if (first_ps_cyc == 0) first_ps_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    @(negedge clk);
    bus.en_reg_out_7_0  = eo[7:0];
    bus.en_reg_out_15_8 = eo[15:8];
    bus.en_reg_pwm_7_0  = ep[7:0];
    bus.en_reg_pwm_15_8 = ep[15:8];
  endtask

  task automatic set_duty(input logic [7:0] d);
    @(negedge clk);
    bus.pwm_duty_cycle = d;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_ps();
    int start;
    int budget;
    start  = ps_count;
    budget = PERIOD + 200;
    while (ps_count == start && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (ps_count == start) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_period_start: no pulse within %0d cycles", PERIOD + 200);
    end
  endtask

  task automatic check_period_hi(input string name);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(name, last_hi, int'(e));
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; ps_count = 0; last_hi = 0;
    bus.en_reg_out_7_0 = 8'h00; bus.en_reg_out_15_8 = 8'h00;
    bus.en_reg_pwm_7_0 = 8'h00; bus.en_reg_pwm_15_8 = 8'h00;
    bus.pwm_duty_cycle = 8'h00;
    rst_n = 1'b0;
    #1;
    check("reset_out", int'(bus.out), 0);
    check("reset_ps", int'(bus.period_start), 0);
    repeat (3) @(negedge clk);
    #10 rst_n = 1'b1;

    // static enables
    set_en(16'h0001, 16'h0000);
    wait_cycles(1);
    check("en_bit0", int'(bus.out), 16'h0001);
    set_en(16'h8001, 16'h0000);
    wait_cycles(1);
    check("en_bit15", int'(bus.out), 16'h8001);
    set_en(16'h8000, 16'h0000);
    wait_cycles(1);
    check("en_clear_low", int'(bus.out), 16'h8000);

    // full PWM at 50 %
    set_en(16'hFFFF, 16'hFFFF);
    set_duty(8'h80);
    wait_ps();
    check("first_ps_cycle", first_ps_cyc, PERIOD);
    set_duty(8'h00);
    wait_ps();
    exp_q.push_back(32'd1664);
    check_period_hi("hi_duty_80");
    set_duty(8'hFF);
    wait_ps();
    exp_q.push_back(32'd0);
    check_period_hi("hi_duty_00");
    wait_ps();
    exp_q.push_back(32'd3328);
    check_period_hi("hi_duty_ff");
    set_duty(8'h40);
    wait_ps();
    exp_q.push_back(32'd3328);
    check_period_hi("hi_duty_ff_across_wrap");

    // mid-period duty change at counter ~100
    wait_cycles(100 * P);
    set_duty(8'hC0);
    wait_ps();
    exp_q.push_back(32'd832);
    check_period_hi("hi_duty_40_old_kept");
    set_en(16'h00FF, 16'h000F);
    set_duty(8'h40);
    wait_ps();
    exp_q.push_back(32'd2496);
    check_period_hi("hi_duty_c0_next");

    // mixed mode during a 0x40 period
    wait_ps();
    wait_cycles(10);
    check("mixed_early", int'(bus.out), 16'h00FF);
    wait_cycles(70 * P);
    check("mixed_late", int'(bus.out), 16'h00F0);

    // asynchronous reset mid-period
    @(posedge clk);
    #20 rst_n = 1'b0;
    #1;
    check("async_reset_out", int'(bus.out), 0);
    check("async_reset_ps", int'(bus.period_start), 0);
    repeat (2) @(negedge clk);
    #10 rst_n = 1'b1;
    wait_ps();
    check("restart_first_ps_cycle", first_ps_cyc, PERIOD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
